// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: burst read/write responder backed by a 64-bit word RAM for the flat cbus.
// Define CBUS_MEM_RANDOM_READY_EN to stall beats pseudo-randomly from a 16-bit LFSR.
module cbus_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrobe_i,
    input  logic [1:0]  burst_i,
    input  logic [7:0]  len_i,
    input  logic [2:0]  size_i,
    output logic [63:0] rdata_o,
    output logic        ready_o,
    output logic        last_o
);
    typedef enum logic [1:0] {IDLE, WAIT, BEAT, GAP} state_t;
    state_t      state_q;
    logic [63:0] mem [2**ADDR_WIDTH];
    logic [63:0] base_q, cur_q, rdata_q, step, wmask, beat_d, pres_a, rd_word;
    logic [7:0]  len_q, i_q, i_d, pres_i, pres_len;
    logic [3:0]  cnt_q;
    logic [1:0]  burst_q, size_q;
    logic        wr_q, ready_q, last_q, wrap_ok, pres_wr, issue, we, go, unused_ok;

`ifdef CBUS_MEM_RANDOM_READY_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign go = lfsr_d[0];
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) lfsr_q <= 16'hACE1;
        else lfsr_q <= lfsr_d;
    end
`else
    assign go = 1'b1;
`endif

    // pres_* describe the beat that will be presented next cycle if issue is set
    always_comb begin
        i_d      = i_q + 8'd1;
        step     = {56'd0, i_d} << size_q;
        wmask    = (({56'd0, len_q} + 64'd1) << size_q) - 64'd1;
        wrap_ok  = burst_q == 2'd2 && (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
        beat_d   = burst_q == 2'd0 ? base_q : wrap_ok ? (base_q & ~wmask) | ((base_q + step) & wmask) : base_q + step;
        pres_a   = state_q == IDLE ? addr_i : ready_q ? beat_d : cur_q;
        pres_i   = state_q == IDLE ? 8'd0 : ready_q ? i_d : i_q;
        pres_len = state_q == IDLE ? len_i : len_q;
        pres_wr  = state_q == IDLE ? |wstrobe_i : wr_q;
        issue    = valid_i && (state_q == IDLE ? LATENCY == 0 :
                               state_q == WAIT ? cnt_q <= 4'd1 :
                               state_q == BEAT && !(ready_q && i_q == len_q));
    end

    assign rd_word   = mem[pres_a[ADDR_WIDTH+2:3]];
    assign we        = state_q == BEAT && ready_q && wr_q && valid_i;
    assign unused_ok = ^{pres_a[63:ADDR_WIDTH+3], pres_a[2:0]};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            i_q     <= '0;
            base_q  <= '0;
            cur_q   <= '0;
            burst_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q <= state_q == WAIT ? cnt_q - 4'd1 : 4'(LATENCY);
            if (state_q == IDLE) begin
                base_q  <= addr_i;
                cur_q   <= addr_i;
                i_q     <= '0;
                burst_q <= burst_i;
                len_q   <= len_i;
                size_q  <= size_i > 3'd3 ? 2'd3 : size_i[1:0];
                wr_q    <= |wstrobe_i;
            end
            if (issue) begin
                cur_q <= pres_a;
                i_q   <= pres_i;
            end
            state_q <= issue ? BEAT : (!valid_i || state_q == GAP) ? IDLE : state_q == BEAT ? GAP : WAIT;
            ready_q <= issue && go;
            last_q  <= issue && go && pres_i == pres_len;
            rdata_q <= (issue && go && !pres_wr) ? rd_word : '0;
        end
    end

    // write lanes use live wdata/wstrobe; an abandoned beat (valid low) commits nothing
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 8; k++)
            if (we && wstrobe_i[k]) mem[cur_q[ADDR_WIDTH+2:3]][8*k +: 8] <= wdata_i[8*k +: 8];
    end

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign last_o  = last_q;
endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: directed bus transactions checked against a byte-lane RAM model and a read scoreboard.
module tb_cbus_mem_responder;
    logic        clk = 1'b0;
    logic        reset, valid;
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  wstrobe, len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic        ready, last;
    logic        rd_active;
    int          total = 0, passed = 0;
    logic [63:0] model [4096];
    logic [64:0] expq[$];

    always #5 clk = ~clk;

    cbus_mem_responder dut (
        .clk_i(clk), .reset_i(reset), .valid_i(valid), .addr_i(addr), .wdata_i(wdata),
        .wstrobe_i(wstrobe), .burst_i(burst), .len_i(len), .size_i(size),
        .rdata_o(rdata), .ready_o(ready), .last_o(last)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] baddr(input logic [63:0] a, input logic [1:0] b, input logic [7:0] l,
                                          input logic [2:0] s, input int j);
        logic [63:0] bs, w, lin;
        bs  = 64'd1 << (s > 3'd3 ? 3'd3 : s);
        lin = a + 64'(j) * bs;
        w   = (64'(l) + 64'd1) * bs;
        if (b == 2'd0) return a;
        if (b == 2'd2 && (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) return (a & ~(w - 64'd1)) | (lin & (w - 64'd1));
        return lin;
    endfunction

    always @(negedge clk) begin
        if (ready && rd_active) begin
            if (expq.size() == 0) chk("unexpected_read_beat", 64'(expq.size()), 64'd1);
            else begin
                logic [64:0] e;
                e = expq.pop_front();
                chk("rdata", rdata, e[64:1]);
                chk("rlast", 64'(last), 64'(e[0]));
            end
        end
    end

    // stop = number of beats after which the task returns with valid still high (abort scenarios)
    task automatic xfer(input logic [63:0] a, input logic [1:0] b, input logic [7:0] l, input logic [2:0] s,
                        input logic [7:0] ws, input logic [63:0] wd, input int stop);
        int cyc, beats, first, lastc;
        logic [63:0] ea;
        if (ws == 8'd0)
            for (int j = 0; j <= int'(l); j++) begin
                ea = baddr(a, b, l, s, j);
                expq.push_back({model[ea[14:3]], j == int'(l)});
            end
        valid = 1'b1; addr = a; burst = b; len = l; size = s; wstrobe = ws; wdata = wd;
        rd_active = (ws == 8'd0);
        cyc = 0; beats = 0; first = -1; lastc = -1;
        while (beats <= int'(l) && beats < stop && cyc < 400) begin
            @(negedge clk);
            if (ready) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                if (ws != 8'd0) begin
                    chk("wlast", 64'(last), 64'(beats == int'(l)));
                    chk("wrdata_zero", rdata, 64'd0);
                    ea = baddr(a, b, l, s, beats);
                    for (int k = 0; k < 8; k++)
                        if (wstrobe[k]) model[ea[14:3]][8*k +: 8] = wdata[8*k +: 8];
                end
                beats++;
            end
            @(posedge clk); #1;
            wdata = wd + 64'(beats);
            cyc++;
        end
        chk("first_ready_cycle", 64'(first), 64'd3);
        if (stop > int'(l)) begin
            chk("beat_count", 64'(beats), 64'(l) + 64'd1);
            chk("contiguous", 64'(lastc - first), 64'(l));
            @(negedge clk);
            chk("gap_ready", 64'(ready), 64'd0);
            valid = 1'b0; wstrobe = 8'd0; rd_active = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrobe = '0; burst = '0; len = '0; size = '0;
        rd_active = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_last", 64'(last), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        xfer(64'h80, 2'd1, 8'd0, 3'd3, 8'hFF, 64'h1122334455667788, 99);
        xfer(64'h80, 2'd1, 8'd0, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h80, 2'd1, 8'd0, 3'd3, 8'h0F, 64'hAAAAAAAABBBBBBBB, 99);
        xfer(64'h80, 2'd1, 8'd0, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h100, 2'd1, 8'd3, 3'd3, 8'hFF, 64'h20, 99);
        xfer(64'h100, 2'd1, 8'd3, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h118, 2'd2, 8'd3, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h108, 2'd0, 8'd1, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h100, 2'd1, 8'd3, 3'd2, 8'h00, 64'd0, 99);
        xfer(64'h8110, 2'd3, 8'd1, 3'd7, 8'h00, 64'd0, 99);
        xfer(64'h118, 2'd2, 8'd2, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h0, 2'd1, 8'd7, 3'd3, 8'hFF, 64'h900, 99);
        xfer(64'h0, 2'd1, 8'd7, 3'd3, 8'hFF, 64'h5000, 2);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_ready", 64'(ready), 64'd0);
        chk("abort_last", 64'(last), 64'd0);
        @(negedge clk);
        chk("abort_idle", 64'(ready), 64'd0);
        wstrobe = 8'd0;
        @(posedge clk); #1;
        xfer(64'h0, 2'd1, 8'd7, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h0, 2'd1, 8'd7, 3'd3, 8'h00, 64'd0, 2);
        rd_active = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midreset_ready", 64'(ready), 64'd0);
        chk("midreset_last", 64'(last), 64'd0);
        chk("midreset_rdata", rdata, 64'd0);
        expq.delete();
        valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        xfer(64'h80, 2'd1, 8'd0, 3'd3, 8'h00, 64'd0, 99);
        xfer(64'h110, 2'd1, 8'd1, 3'd3, 8'h00, 64'd0, 99);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Synthesizable memory-side responder for the flat cbus master interface exported by the CPU top.
- Accepts single and burst read/write requests.
- Returns per-beat ready/last handshakes and read data from an internal 64-bit word RAM.
- Used as the simulation/FPGA backing memory behind the core, and as the reference responder for bus-level verification.

Parameters:
- ADDR_WIDTH, 12, log2 of RAM depth in 64-bit words (4096 words = 32 KiB).
- LATENCY, 2, idle cycles inserted between request acceptance and the first beat (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid  input  1  request valid; held by initiator until the last beat is handshaken.
- addr  input  64  request byte address.
- wdata  input  64  write data for the current beat.
- wstrobe  input  8  byte enables; nonzero marks a write request, all-zero marks a read.
- burst  input  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved (treated as INCR).
- len  input  8  number of beats minus 1 (1..256 beats).
- size  input  3  bytes per beat = 2^size; only 0..3 are legal, values >3 are treated as 3.
- rdata  output  64  read data, valid only while ready=1 on a read.
- ready  output  1  beat handshake; one beat completes on every cycle ready=1.
- last  output  1  high together with ready on the final beat.

Behaviour:
- Reset is asynchronous and active-high: clk is the single clock; reset asserted forces state to IDLE and ready=0, last=0, rdata=0, and clears all counters immediately. RAM contents are not cleared.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, WAIT, BEAT, GAP.
- IDLE: on valid=1, capture addr, burst, len, size and is_write=|wstrobe; load the latency counter with LATENCY. Go to WAIT, or go straight to BEAT if LATENCY=0.
- WAIT: decrement the counter each cycle; enter BEAT when it reaches 0.
- Timing: the first ready is high on cycle 1+LATENCY, counting the IDLE cycle where valid is sampled as cycle 0.
- BEAT: ready=1 on each beat cycle; the beat counter i runs 0..len. last=1 exactly when i==len. After the last beat, go to GAP.
- GAP: one cycle with ready=0 and valid ignored, which gives the initiator time to drop or change its request. Then go to IDLE.
- Beat byte address, with B=2^size:
  - FIXED: A_i = addr.
  - INCR: A_i = addr + i*B, 64-bit wrap-around.
  - WRAP: boundary W=(len+1)*B. A_i = (addr & ~(W-1)) | ((addr + i*B) & (W-1)). The initiator must use len+1 in {2,4,8,16}; any other value is treated as INCR.
- RAM index = A_i[ADDR_WIDTH+2:3]. Upper address bits are ignored, so addresses alias.
- Read beat: rdata = full 64-bit word RAM[index] in the same cycle ready=1. The initiator extracts sub-word lanes itself. rdata=0 whenever ready=0 and on all write beats.
- Write beat: on the rising edge that ends a ready=1 cycle, for each k with wstrobe[k]=1, RAM[index][8k+7:8k] <= wdata[8k+7:8k].
  - wstrobe and wdata are sampled live each beat.
  - A beat whose wstrobe is 0 writes nothing; the transaction stays a write.
- Read-after-write: a read issued after a completed write returns the new data. No bypass is needed, because GAP plus the latency guarantee ordering.
- valid dropping before last is a protocol violation. The responder returns to IDLE on the next edge with ready=0, last=0, and the remaining beats are abandoned. Writes already performed stay.
- Request fields changing mid-transaction are ignored, since the captured copies are used. The exception is wdata and wstrobe, which are read per beat.
- Reset asserted mid-burst: immediate return to IDLE. A partially written burst leaves its earlier beats committed.

Optional Feature:
- Macro: CBUS_MEM_RANDOM_READY_EN.
- With the macro defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, reset to seed) advances every cycle.
  - In BEAT, a beat is issued only on cycles where lfsr[0]=1. Otherwise ready=0, and i, the address and the RAM are unchanged.
  - This stresses initiator stall handling.
- Without the macro: no LFSR; ready=1 on every BEAT cycle, so a burst of len+1 beats is contiguous.

Test Plan:
- Reset, then single write addr=0x80, len=0, size=3, wstrobe=0xFF, wdata=0x1122334455667788 -> ready=last=1 on cycle 3 (LATENCY=2). A following read of 0x80 returns 0x1122334455667788 with last=1.
- Partial write: wstrobe=0x0F, wdata=0xAAAAAAAABBBBBBBB to 0x80 -> read returns 0x11223344BBBBBBBB.
- INCR read burst addr=0x100, len=3, size=3, with RAM preloaded word k = k -> rdata 0x20,0x21,0x22,0x23 on 4 consecutive ready cycles, last only on the 4th, then one GAP cycle with ready=0.
- WRAP read burst addr=0x118, len=3, size=3 -> word indices 0x23,0x20,0x21,0x22.
- Abort: valid dropped after beat 1 of a len=7 write -> ready=0 next cycle, FSM in IDLE; only words 0 and 1 modified. Reset asserted mid-burst -> ready and last go to 0 asynchronously.
- With CBUS_MEM_RANDOM_READY_EN: len=15 INCR read -> exactly 16 ready pulses with gaps, data in address order, last on the 16th.
